control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Instruction-consuming end of the instruction memory / PC interface.
- Latches the 10-bit instruction presented by the instruction memory and sequences the datapath through a multi-cycle T0..T3 state machine.
- Drives done, branch, branchaddress and export_pc back to the PC so the memory advances, jumps or exposes its PC.
- Holds the link register used by LDPC, SVPC and BXLR.

Parameters:
- OP_SIZE, 4, opcode width
- ARG_SIZE, 3, register-field width
- ARG_NUM, 2, number of register fields; instruction width IW = OP_SIZE + ARG_NUM*ARG_SIZE = 10
- ADDR_W, 6, PC / branch address width (= ARG_NUM*ARG_SIZE)
- NREG, 6, general registers R1..R6

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- run  in  1  sampled in T0; 1 = fetch and execute the next instruction
- instruction  in  IW  current instruction from memory (combinational from pc)
- in_pc  in  ADDR_W  memory PC, valid only while export_pc = 1
- done  out  1  one-cycle pulse; memory increments pc on the same edge
- branch  out  1  one-cycle pulse; memory loads branchaddress on the same edge
- branchaddress  out  ADDR_W  branch target, valid while branch = 1, else 0
- export_pc  out  1  requests in_pc
- din_out  out  1  drives external data onto the bus (LOAD)
- r_in  out  NREG  one-hot register write enables, bit k-1 = Rk
- r_out  out  NREG  one-hot register bus-drive enables
- a_in  out  1  load ALU A register
- g_in  out  1  load ALU G register
- g_out  out  1  drive G onto bus
- alu_xor  out  1  0 = ADD, 1 = XOR; meaningful with g_in
- illegal  out  1  one-cycle pulse on an undefined opcode
- busy  out  1  1 in any state other than T0

Behaviour:
- Register codes: 000 NA, 001..110 R1..R6, 111 PC.
  - NA or PC as a destination produces no r_in bit.
  - NA or PC as a source produces no r_out bit.
- Opcodes:
  - 0000 LOAD, 0001 MOVE, 0010 ADD, 0011 XOR, 0100 BRN, 0101 LDPC, 0110 BXLR, 0111 SVPC.
  - 1xxx illegal.
  - imm6 = instruction[5:0].
- State machine: T0, T1, T2, T3.
- All outputs are decoded from the state and the IR/link registers (Moore). No output depends combinationally on the instruction input.
- T0:
  - If run = 1: IR <= instruction, go to T1. Otherwise stay in T0.
  - No outputs asserted.
- T1 actions, by opcode (each ends the instruction and returns to T0 unless stated):
  - LOAD: din_out = 1, r_in[X] = 1, done = 1.
  - MOVE: r_out[Y] = 1, r_in[X] = 1, done = 1.
  - ADD/XOR: r_out[X] = 1, a_in = 1, go to T2.
  - BRN: branch = 1, branchaddress = imm6. No done.
  - LDPC: link <= imm6, done = 1.
  - BXLR: branch = 1, branchaddress = link. No done.
  - SVPC: export_pc = 1, link <= in_pc + 1 (mod 64), done = 1.
  - Illegal: illegal = 1, done = 1 (treated as NOP).
- T2 (ADD/XOR): r_out[Y] = 1, g_in = 1, alu_xor = (op == XOR), go to T3.
- T3: g_out = 1, r_in[X] = 1, done = 1, return to T0.
- Instruction latency: LOAD, MOVE, BRN, LDPC, BXLR, SVPC, illegal = 2 cycles; ADD/XOR = 4 cycles.
- done and branch are never asserted together.
- At most one r_out bit is active in any cycle, and never together with din_out or g_out.
- Branch targets wrap naturally in ADDR_W bits. in_pc + 1 with in_pc = 63 gives 0.
- Self-reference: ADD R1,R1 is legal. A captures R1 in T1; the sum 2*R1 is written in T3.
- run deasserted mid-instruction has no effect; only T0 samples run.
- Reset (synchronous):
  - state <= T0, IR <= 0, link <= 0.
  - All outputs 0 in the following cycle.
  - Reset mid-instruction aborts with no done or branch pulse.
  - rst has priority over run.

Decomposition:
- Package ctrl_pkg: opcode constants, register-code constants (NA, R1..R6, PC), state encoding, IW and ADDR_W derived constants.
- Sub-module reg_sel_decode: combinational 3-bit code -> NREG one-hot map, with NA/PC mapping to 0. Instantiated twice (X field, Y field).

Test Plan:
- Reset, run = 1, instruction = LOAD R1,NA -> in T1: din_out = 1, r_in = 000001, done = 1; back in T0 the next cycle; busy low.
- ADD R2,R3 (0010_010_011) -> T1: r_out = 000010 and a_in. T2: r_out = 000100, g_in, alu_xor = 0. T3: g_out, r_in = 000010, done. Exactly 4 cycles. XOR variant gives alu_xor = 1 in T2.
- Call/return sequence:
  - LDPC 000100 -> link = 4, done pulse.
  - BRN 000001 -> branch = 1, branchaddress = 1, done = 0.
  - BXLR PC,PC -> branch = 1, branchaddress = 4.
- SVPC with in_pc = 63 -> export_pc = 1 in T1, link = 0. A following BXLR gives branchaddress = 0.
- Opcode 1010 -> illegal pulse and done in T1; no r_in, r_out or branch activity. MOVE NA,R1 -> r_in = 0, r_out = 000001, done.
- rst asserted in T2 of an ADD -> no done or g_out ever; T0 with all outputs 0 the next cycle; link cleared. run = 0 -> remains in T0 indefinitely.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared widths, opcodes, register codes and state encoding for control_unit
package ctrl_pkg;
  localparam int OP_SIZE = 4;
  localparam int ARG_SIZE = 3;
  localparam int ARG_NUM = 2;
  localparam int IW = OP_SIZE + ARG_NUM * ARG_SIZE;
  localparam int ADDR_W = ARG_NUM * ARG_SIZE;
  localparam int NREG = 6;
  localparam logic [OP_SIZE-1:0] OP_LOAD = 4'b0000;
  localparam logic [OP_SIZE-1:0] OP_MOVE = 4'b0001;
  localparam logic [OP_SIZE-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_SIZE-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_SIZE-1:0] OP_BRN  = 4'b0100;
  localparam logic [OP_SIZE-1:0] OP_LDPC = 4'b0101;
  localparam logic [OP_SIZE-1:0] OP_BXLR = 4'b0110;
  localparam logic [OP_SIZE-1:0] OP_SVPC = 4'b0111;
  localparam logic [ARG_SIZE-1:0] RC_NA = 3'b000;
  localparam logic [ARG_SIZE-1:0] RC_R1 = 3'b001;
  localparam logic [ARG_SIZE-1:0] RC_R2 = 3'b010;
  localparam logic [ARG_SIZE-1:0] RC_R3 = 3'b011;
  localparam logic [ARG_SIZE-1:0] RC_R4 = 3'b100;
  localparam logic [ARG_SIZE-1:0] RC_R5 = 3'b101;
  localparam logic [ARG_SIZE-1:0] RC_R6 = 3'b110;
  localparam logic [ARG_SIZE-1:0] RC_PC = 3'b111;
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
endpackage

// File: rtl/reg_sel_decode.sv
// reg_sel_decode: register code to one-hot R1..R6 select; NA and PC select nothing
module reg_sel_decode
  import ctrl_pkg::*;
(
  input  logic [ARG_SIZE-1:0] code,
  output logic [NREG-1:0]     sel
);
  always_comb sel = (code == RC_NA || code == RC_PC) ? '0 : NREG'(1) << (code - RC_R1);
endmodule

// File: rtl/control_unit.sv
// control_unit: latches instructions and sequences the datapath through T0..T3 with a link register
module control_unit
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [IW-1:0]     instruction,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              done,
  output logic              branch,
  output logic [ADDR_W-1:0] branchaddress,
  output logic              export_pc,
  output logic              din_out,
  output logic [NREG-1:0]   r_in,
  output logic [NREG-1:0]   r_out,
  output logic              a_in,
  output logic              g_in,
  output logic              g_out,
  output logic              alu_xor,
  output logic              illegal,
  output logic              busy
);
  state_t state;
  logic [IW-1:0] ir;
  logic [ADDR_W-1:0] link;
  logic [NREG-1:0] x_sel, y_sel;
  logic [OP_SIZE-1:0] op;
  logic [ADDR_W-1:0] imm;
  logic t1, t2, t3, arith, jump;
  assign op = ir[IW-1 -: OP_SIZE];
  assign imm = ir[ADDR_W-1:0];
  reg_sel_decode x_dec (.code(ir[2*ARG_SIZE-1 -: ARG_SIZE]), .sel(x_sel));
  reg_sel_decode y_dec (.code(ir[ARG_SIZE-1:0]), .sel(y_sel));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T0;
      ir <= '0;
      link <= '0;
    end else begin
      case (state)
        T0: if (run) begin
          ir <= instruction;
          state <= T1;
        end
        T1: begin
          if (op == OP_LDPC) link <= imm;
          if (op == OP_SVPC) link <= in_pc + ADDR_W'(1);
          state <= arith ? T2 : T0;
        end
        T2: state <= T3;
        default: state <= T0;
      endcase
    end
  end
  // Outputs are pure decodes of state and the latched IR/link, never of the instruction input
  always_comb begin
    t1 = state == T1;
    t2 = state == T2;
    t3 = state == T3;
    arith = op == OP_ADD || op == OP_XOR;
    jump = op == OP_BRN || op == OP_BXLR;
    busy = state != T0;
    din_out = t1 && op == OP_LOAD;
    a_in = t1 && arith;
    g_in = t2;
    alu_xor = t2 && op == OP_XOR;
    g_out = t3;
    r_in = ((t1 && (op == OP_LOAD || op == OP_MOVE)) || t3) ? x_sel : '0;
    r_out = (t1 && op == OP_MOVE) || t2 ? y_sel : (t1 && arith) ? x_sel : '0;
    branch = t1 && jump;
    branchaddress = !branch ? '0 : op == OP_BRN ? imm : link;
    export_pc = t1 && op == OP_SVPC;
    illegal = t1 && op[OP_SIZE-1];
    done = (t1 && !arith && !jump) || t3;
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector table, hand sequences and random instructions vs a cycle-action model
module tb_control_unit;
  typedef struct packed {
    logic done, branch;
    logic [5:0] ba;
    logic export_pc, din_out;
    logic [5:0] r_in, r_out;
    logic a_in, g_in, g_out, alu_xor, illegal, busy;
  } out_t;
  logic clk = 0, rst = 1, run = 0;
  logic [9:0] instruction = '0;
  logic [5:0] in_pc = '0;
  logic done, branch, export_pc, din_out, a_in, g_in, g_out, alu_xor, illegal, busy;
  logic [5:0] branchaddress, r_in, r_out;
  out_t act;
  int total = 0, bad = 0;
  logic [5:0] mlink = '0;
  string tn[12];
  logic [9:0] ti[12];
  logic [5:0] tp[12];
  int tcnt[12];
  out_t te[12][3];
  int nt = 0;
  control_unit dut (.clk(clk), .rst(rst), .run(run), .instruction(instruction), .in_pc(in_pc),
    .done(done), .branch(branch), .branchaddress(branchaddress), .export_pc(export_pc),
    .din_out(din_out), .r_in(r_in), .r_out(r_out), .a_in(a_in), .g_in(g_in), .g_out(g_out),
    .alu_xor(alu_xor), .illegal(illegal), .busy(busy));
  always #5 clk = ~clk;
  assign act = {done, branch, branchaddress, export_pc, din_out, r_in, r_out, a_in, g_in, g_out,
    alu_xor, illegal, busy};
  task automatic chk(string nm, out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  // f = {done, branch, export_pc, din_out, a_in, g_in, g_out, alu_xor, illegal}
  function automatic out_t mk(logic [5:0] rin, logic [5:0] rout, logic [5:0] ba, logic [8:0] f);
    out_t o = '0;
    o.r_in = rin;
    o.r_out = rout;
    o.ba = ba;
    {o.done, o.branch, o.export_pc, o.din_out, o.a_in, o.g_in, o.g_out, o.alu_xor, o.illegal} = f;
    o.busy = 1;
    return o;
  endfunction
  function automatic logic [5:0] oh(logic [2:0] c);
    return (c >= 1 && c <= 6) ? 6'(1 << (c - 1)) : 6'd0;
  endfunction
  function automatic int lat(logic [9:0] i);
    return (i[9:6] == 4'd2 || i[9:6] == 4'd3) ? 4 : 2;
  endfunction
  // expected outputs k cycles after the instruction is accepted
  function automatic out_t model(logic [9:0] i, int k, logic [5:0] lk);
    logic [3:0] op;
    logic [5:0] x, y;
    out_t o;
    op = i[9:6];
    x = oh(i[5:3]);
    y = oh(i[2:0]);
    o = '0;
    o.busy = 1;
    if (op[3]) begin
      o.illegal = 1;
      o.done = 1;
    end else if (op == 2 || op == 3) begin
      if (k == 0) begin o.r_out = x; o.a_in = 1; end
      else if (k == 1) begin o.r_out = y; o.g_in = 1; o.alu_xor = op[0]; end
      else begin o.g_out = 1; o.r_in = x; o.done = 1; end
    end else begin
      o.branch = op == 4 || op == 6;
      o.done = !o.branch;
      o.ba = op == 4 ? i[5:0] : op == 6 ? lk : 6'd0;
      o.din_out = op == 0;
      o.r_in = op <= 1 ? x : 6'd0;
      o.r_out = op == 1 ? y : 6'd0;
      o.export_pc = op == 7;
    end
    return o;
  endfunction
  function automatic logic [5:0] next_link(logic [9:0] i, logic [5:0] pc, logic [5:0] lk);
    return i[9:6] == 4'd5 ? i[5:0] : i[9:6] == 4'd7 ? pc + 6'd1 : lk;
  endfunction
  task automatic accept(logic [9:0] i, logic [5:0] pc);
    @(negedge clk);
    instruction = i;
    in_pc = pc;
    run = 1;
    @(posedge clk);
    #1;
    run = 0;
    instruction = 10'($urandom);
  endtask
  task automatic run_model(string nm, logic [9:0] i, logic [5:0] pc);
    accept(i, pc);
    for (int k = 0; k < lat(i) - 1; k++) begin
      chk(nm, model(i, k, mlink));
      @(posedge clk);
      #1;
    end
    chk({nm, "_t0"}, '0);
    mlink = next_link(i, pc, mlink);
  endtask
  task automatic add(string nm, logic [9:0] i, logic [5:0] pc, int n, out_t e0, out_t e1, out_t e2);
    tn[nt] = nm; ti[nt] = i; tp[nt] = pc; tcnt[nt] = n;
    te[nt][0] = e0; te[nt][1] = e1; te[nt][2] = e2;
    nt++;
  endtask
  initial begin
    add("load_r1", 10'b0000_001_000, 0, 1, mk(6'b000001, 0, 0, 9'b100100000), '0, '0);
    add("add_r2r3", 10'b0010_010_011, 0, 3, mk(0, 6'b000010, 0, 9'b000010000),
      mk(0, 6'b000100, 0, 9'b000001000), mk(6'b000010, 0, 0, 9'b100000100));
    add("xor_r4r5", 10'b0011_100_101, 0, 3, mk(0, 6'b001000, 0, 9'b000010000),
      mk(0, 6'b010000, 0, 9'b000001010), mk(6'b001000, 0, 0, 9'b100000100));
    add("ldpc4", 10'b0101_000_100, 0, 1, mk(0, 0, 0, 9'b100000000), '0, '0);
    add("brn1", 10'b0100_000_001, 0, 1, mk(0, 0, 6'd1, 9'b010000000), '0, '0);
    add("bxlr4", 10'b0110_111_111, 0, 1, mk(0, 0, 6'd4, 9'b010000000), '0, '0);
    add("svpc63", 10'b0111_000_000, 6'd63, 1, mk(0, 0, 0, 9'b101000000), '0, '0);
    add("bxlr0", 10'b0110_000_000, 0, 1, mk(0, 0, 6'd0, 9'b010000000), '0, '0);
    add("illegal", 10'b1010_001_010, 0, 1, mk(0, 0, 0, 9'b100000001), '0, '0);
    add("move_na_r1", 10'b0001_000_001, 0, 1, mk(0, 6'b000001, 0, 9'b100000000), '0, '0);
    add("add_r1r1", 10'b0010_001_001, 0, 3, mk(0, 6'b000001, 0, 9'b000010000),
      mk(0, 6'b000001, 0, 9'b000001000), mk(6'b000001, 0, 0, 9'b100000100));
    add("move_r6_pc", 10'b0001_110_111, 0, 1, mk(6'b100000, 0, 0, 9'b100000000), '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", '0);
    @(negedge clk);
    rst = 0;
    for (int t = 0; t < nt; t++) begin
      accept(ti[t], tp[t]);
      for (int k = 0; k < tcnt[t]; k++) begin
        chk(tn[t], te[t][k]);
        @(posedge clk);
        #1;
      end
      chk({tn[t], "_t0"}, '0);
    end
    // rst has priority over run
    @(negedge clk);
    rst = 1; run = 1; instruction = 10'b0000_001_000;
    @(posedge clk);
    #1;
    chk("rst_prio", '0);
    @(negedge clk);
    rst = 0; run = 0;
    mlink = '0;
    run_model("ldpc42", 10'b0101_101010, 0);
    // reset in T2 of an ADD aborts it and clears link
    accept(10'b0010_010_011, 0);
    chk("abort_t1", model(10'b0010_010_011, 0, mlink));
    @(posedge clk);
    #1;
    chk("abort_t2", model(10'b0010_010_011, 1, mlink));
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("abort_rst", '0);
    @(negedge clk);
    rst = 0;
    mlink = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("idle", '0);
    end
    run_model("bxlr_after_rst", 10'b0110_000_000, 0);
    for (int n = 0; n < 300; n++) begin
      logic [9:0] ri;
      ri = 10'($urandom);
      run_model("rand", ri, 6'($urandom));
      if (($urandom & 7) == 0) begin
        @(posedge clk);
        #1;
        chk("rand_idle", '0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
